// File: rtl/mips_arith_sequencer_if.sv
// rtl/mips_arith_sequencer_if.sv - instruction, register file, ALU and trap signals of the arithmetic sequencer
interface mips_arith_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             inst_valid;
  logic [31:0]      inst;
  logic             inst_ready;
  logic [4:0]       rs_num;
  logic [4:0]       rt_num;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;
  logic [4:0]       rd_num;
  logic [WIDTH-1:0] rd_data;
  logic             rd_we;
  logic             except;
  logic             except_ack;
  logic             busy;

  modport master (
    input  inst_valid, inst, rs_data, rt_data, alu_out, except_ack,
    output inst_ready, rs_num, rt_num, alu_op, alu_a, alu_b,
           rd_num, rd_data, rd_we, except, busy
  );

  modport slave (
    output inst_valid, inst, rs_data, rt_data, alu_out, except_ack,
    input  inst_ready, rs_num, rt_num, alu_op, alu_a, alu_b,
           rd_num, rd_data, rd_we, except, busy
  );
endinterface

// File: rtl/mips_arith_sequencer.sv
// rtl/mips_arith_sequencer.sv - multi-cycle IDLE/DECODE/EXEC/WB/TRAP sequencer for the MIPS arithmetic subset
// Optional retired/trap counters are enabled with ARITH_SEQ_PERF_EN.
module mips_arith_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  mips_arith_sequencer_if.master bus
`ifdef ARITH_SEQ_PERF_EN
  ,
  output logic [15:0]           retired_count,
  output logic [15:0]           trap_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_TRAP
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             inst_ready_q, inst_ready_d;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             dec_legal;
  logic             dec_rtype;
  logic             dec_sext;
  logic [2:0]       dec_op;
  logic [WIDTH-1:0] imm_ext;
  logic             unused_shamt;

  assign opcode       = ir_q[31:26];
  assign funct        = ir_q[5:0];
  assign unused_shamt = ^ir_q[10:6];

  always_comb begin
    dec_legal = 1'b0;
    dec_rtype = 1'b0;
    dec_sext  = 1'b0;
    dec_op    = 3'b000;
    if (opcode == 6'h00) begin
      dec_rtype = 1'b1;
      dec_legal = 1'b1;
      case (funct)
        6'h20:   dec_op = 3'b010;
        6'h22:   dec_op = 3'b011;
        6'h24:   dec_op = 3'b100;
        6'h25:   dec_op = 3'b101;
        6'h26:   dec_op = 3'b111;
        6'h27:   dec_op = 3'b110;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      dec_legal = 1'b1;
      case (opcode)
        6'h08: begin
          dec_op   = 3'b010;
          dec_sext = 1'b1;
        end
        6'h0C:   dec_op = 3'b100;
        6'h0D:   dec_op = 3'b101;
        6'h0E:   dec_op = 3'b111;
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // Only addi sign-extends; the logical immediates are zero-extended.
  assign imm_ext = dec_sext ? {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]}
                            : {{(WIDTH-16){1'b0}}, ir_q[15:0]};

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rd_d    = rd_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (bus.inst_valid) begin
          ir_d    = bus.inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          a_d     = bus.rs_data;
          b_d     = dec_rtype ? bus.rt_data : imm_ext;
          op_d    = dec_op;
          rd_d    = dec_rtype ? ir_q[15:11] : ir_q[20:16];
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        res_d   = bus.alu_out;
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      S_TRAP:  if (bus.except_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    inst_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      res_q        <= '0;
      inst_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      res_q        <= res_d;
      inst_ready_q <= inst_ready_d;
    end
  end

  assign bus.inst_ready = inst_ready_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.rs_num     = (state_q == S_DECODE) ? ir_q[25:21] : 5'd0;
  assign bus.rt_num     = (state_q == S_DECODE) ? ir_q[20:16] : 5'd0;
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rd_num     = rd_q;
  assign bus.rd_data    = res_q;
  assign bus.rd_we      = (state_q == S_WB) && (rd_q != 5'd0);
  assign bus.except     = (state_q == S_TRAP);

`ifdef ARITH_SEQ_PERF_EN
  logic [15:0] retired_q, retired_d;
  logic [15:0] trap_q, trap_d;

  // Register-0 writes still count as retired even though rd_we is suppressed.
  always_comb begin
    retired_d = retired_q;
    trap_d    = trap_q;
    if (state_q == S_WB) retired_d = retired_q + 16'd1;
    if ((state_q == S_DECODE) && !dec_legal) trap_d = trap_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      trap_q    <= '0;
    end else begin
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  assign retired_count = retired_q;
  assign trap_count    = trap_q;
`endif

endmodule

// File: tb/tb_mips_arith_sequencer.sv
// tb/tb_mips_arith_sequencer.sv - table-driven bench for mips_arith_sequencer
module tb_mips_arith_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   exp_retired;
  int   exp_traps;

  mips_arith_sequencer_if #(.WIDTH(32)) bus ();

`ifdef ARITH_SEQ_PERF_EN
  logic [15:0] retired_count;
  logic [15:0] trap_count;
`endif

  mips_arith_sequencer #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .bus           (bus.master)
`ifdef ARITH_SEQ_PERF_EN
    ,
    .retired_count (retired_count),
    .trap_count    (trap_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment ALU: combinational, like the real datapath.
  always_comb begin
    case (bus.alu_op)
      3'b010:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b011:  bus.alu_out = bus.alu_a - bus.alu_b;
      3'b100:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b101:  bus.alu_out = bus.alu_a | bus.alu_b;
      3'b110:  bus.alu_out = ~(bus.alu_a | bus.alu_b);
      3'b111:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_out = 32'd0;
    endcase
  end

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        legal;
    logic [2:0]  op;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_perf(input string name);
`ifdef ARITH_SEQ_PERF_EN
    chk({name, "_retired"}, {16'd0, retired_count}, exp_retired[31:0] & 32'hFFFF);
    chk({name, "_traps"}, {16'd0, trap_count}, exp_traps[31:0] & 32'hFFFF);
`else
    chk({name, "_busy_idle"}, {31'd0, bus.busy}, 32'd0);
`endif
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    bus.rs_data    = v.rs_val;
    bus.rt_data    = v.rt_val;
    bus.inst       = v.inst;
    bus.inst_valid = 1'b1;
    chk({t, "_ready"}, {31'd0, bus.inst_ready}, 32'd1);
    tick();
    bus.inst_valid = 1'b0;
    chk({t, "_dec_rs"}, {27'd0, bus.rs_num}, {27'd0, v.inst[25:21]});
    chk({t, "_dec_rt"}, {27'd0, bus.rt_num}, {27'd0, v.inst[20:16]});
    chk({t, "_dec_ready"}, {31'd0, bus.inst_ready}, 32'd0);
    tick();
    if (v.legal) begin
      chk({t, "_ex_op"}, {29'd0, bus.alu_op}, {29'd0, v.op});
      chk({t, "_ex_a"}, bus.alu_a, v.rs_val);
      chk({t, "_ex_b"}, bus.alu_b, v.b);
      chk({t, "_ex_we"}, {31'd0, bus.rd_we}, 32'd0);
      tick();
      exp_retired++;
      chk({t, "_wb_we"}, {31'd0, bus.rd_we}, {31'd0, v.we});
      chk({t, "_wb_rd"}, {27'd0, bus.rd_num}, {27'd0, v.rd});
      chk({t, "_wb_data"}, bus.rd_data, v.data);
      tick();
      chk({t, "_idle_ready"}, {31'd0, bus.inst_ready}, 32'd1);
      chk({t, "_idle_we"}, {31'd0, bus.rd_we}, 32'd0);
      chk({t, "_hold_op"}, {29'd0, bus.alu_op}, {29'd0, v.op});
    end else begin
      exp_traps++;
      chk({t, "_trap_except"}, {31'd0, bus.except}, 32'd1);
      chk({t, "_trap_we"}, {31'd0, bus.rd_we}, 32'd0);
      bus.except_ack = 1'b1;
      tick();
      bus.except_ack = 1'b0;
      chk({t, "_ack_except"}, {31'd0, bus.except}, 32'd0);
      chk({t, "_ack_ready"}, {31'd0, bus.inst_ready}, 32'd1);
    end
    chk_perf(t);
  endtask

  initial begin
    int acc_cnt;
    int we_cnt;
    int acc_cyc[3];

    checks         = 0;
    errors         = 0;
    exp_retired    = 0;
    exp_traps      = 0;
    reset          = 1'b0;
    bus.inst_valid = 1'b0;
    bus.inst       = 32'd0;
    bus.rs_data    = 32'd0;
    bus.rt_data    = 32'd0;
    bus.except_ack = 1'b0;

    //          inst          rs_val        rt_val        legal op      b             rd     data          we
    vecs[0]  = '{32'h00221820, 32'd5,        32'd7,        1'b1, 3'b010, 32'd7,        5'd3,  32'd12,       1'b1};
    vecs[1]  = '{32'h2024FFFF, 32'd1,        32'd0,        1'b1, 3'b010, 32'hFFFFFFFF, 5'd4,  32'd0,        1'b1};
    vecs[2]  = '{32'h3424FFFF, 32'd1,        32'd0,        1'b1, 3'b101, 32'h0000FFFF, 5'd4,  32'h0000FFFF, 1'b1};
    vecs[3]  = '{32'h00220027, 32'd5,        32'd7,        1'b1, 3'b110, 32'd7,        5'd0,  32'hFFFFFFF8, 1'b0};
    vecs[4]  = '{32'h00222822, 32'd5,        32'd7,        1'b1, 3'b011, 32'd7,        5'd5,  32'hFFFFFFFE, 1'b1};
    vecs[5]  = '{32'h00223024, 32'h0000F0F0, 32'h0000FF00, 1'b1, 3'b100, 32'h0000FF00, 5'd6,  32'h0000F000, 1'b1};
    vecs[6]  = '{32'h00223825, 32'h0000F0F0, 32'h00000F0F, 1'b1, 3'b101, 32'h00000F0F, 5'd7,  32'h0000FFFF, 1'b1};
    vecs[7]  = '{32'h00224026, 32'h000000FF, 32'h0000000F, 1'b1, 3'b111, 32'h0000000F, 5'd8,  32'h000000F0, 1'b1};
    vecs[8]  = '{32'h30298001, 32'hFFFFFFFF, 32'd0,        1'b1, 3'b100, 32'h00008001, 5'd9,  32'h00008001, 1'b1};
    vecs[9]  = '{32'h382A00FF, 32'h00000F0F, 32'd0,        1'b1, 3'b111, 32'h000000FF, 5'd10, 32'h00000FF0, 1'b1};
    vecs[10] = '{32'h202B0001, 32'hFFFFFFFF, 32'd0,        1'b1, 3'b010, 32'd1,        5'd11, 32'd0,        1'b1};
    vecs[11] = '{32'h202C8000, 32'h00010000, 32'd0,        1'b1, 3'b010, 32'hFFFF8000, 5'd12, 32'h00008000, 1'b1};
    vecs[12] = '{32'h00226820, 32'h7FFFFFFF, 32'd1,        1'b1, 3'b010, 32'd1,        5'd13, 32'h80000000, 1'b1};
    vecs[13] = '{32'h00221821, 32'd5,        32'd7,        1'b0, 3'b000, 32'd0,        5'd0,  32'd0,        1'b0};
    vecs[14] = '{32'h3C011234, 32'd5,        32'd7,        1'b0, 3'b000, 32'd0,        5'd0,  32'd0,        1'b0};

    #12;
    chk("rst_ready", {31'd0, bus.inst_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_we", {31'd0, bus.rd_we}, 32'd0);
    chk("rst_except", {31'd0, bus.except}, 32'd0);
    chk("rst_rd_num", {27'd0, bus.rd_num}, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Ack outside TRAP is ignored; then a lw traps and is held for 5 cycles.
    bus.except_ack = 1'b1;
    tick();
    bus.except_ack = 1'b0;
    chk("stray_ack_busy", {31'd0, bus.busy}, 32'd0);
    chk("stray_ack_except", {31'd0, bus.except}, 32'd0);
    bus.inst       = 32'h8C220000;
    bus.inst_valid = 1'b1;
    tick();
    bus.inst_valid = 1'b0;
    chk("lw_dec_except", {31'd0, bus.except}, 32'd0);
    tick();
    exp_traps++;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("lw_hold%0d_except", c), {31'd0, bus.except}, 32'd1);
      chk($sformatf("lw_hold%0d_we", c), {31'd0, bus.rd_we}, 32'd0);
      chk($sformatf("lw_hold%0d_ready", c), {31'd0, bus.inst_ready}, 32'd0);
      tick();
    end
    bus.except_ack = 1'b1;
    tick();
    bus.except_ack = 1'b0;
    chk("lw_ack_except", {31'd0, bus.except}, 32'd0);
    chk("lw_ack_busy", {31'd0, bus.busy}, 32'd0);
    chk_perf("lw");

    // inst_valid held across three back-to-back add instructions.
    bus.inst       = 32'h00221820;
    bus.rs_data    = 32'd5;
    bus.rt_data    = 32'd7;
    bus.inst_valid = 1'b1;
    acc_cnt        = 0;
    we_cnt         = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.inst_ready) begin
        if (acc_cnt < 3) acc_cyc[acc_cnt] = c;
        acc_cnt++;
      end
      if (bus.rd_we) we_cnt++;
      tick();
    end
    bus.inst_valid = 1'b0;
    exp_retired += 3;
    chk("b2b_accepts", acc_cnt, 32'd3);
    chk("b2b_we_pulses", we_cnt, 32'd3);
    if (acc_cnt == 3) begin
      chk("b2b_gap1", acc_cyc[1] - acc_cyc[0], 32'd4);
      chk("b2b_gap2", acc_cyc[2] - acc_cyc[1], 32'd4);
    end
    chk_perf("b2b");

    // Asynchronous reset during EXEC aborts without a writeback.
    bus.inst_valid = 1'b1;
    tick();
    bus.inst_valid = 1'b0;
    tick();
    chk("abort_exec_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_we", {31'd0, bus.rd_we}, 32'd0);
    chk("abort_except", {31'd0, bus.except}, 32'd0);
    chk("abort_ready", {31'd0, bus.inst_ready}, 32'd1);
    exp_retired = 0;
    exp_traps   = 0;
    tick();
    reset = 1'b1;
    tick();
    chk("post_abort_we", {31'd0, bus.rd_we}, 32'd0);
    chk_perf("post_abort");
    run_vec(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
